imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Sits directly downstream of the BIOS word source.
- Captures the 32-bit instruction stream the BIOS emits, one word per clock while bios_active is high, and buffers it in a small FIFO.
- Drains the FIFO into instruction memory through a stallable write port.
- Once the stream has ended and every word is written, pulses cu_start so the control unit takes over at cu_pc.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MEM_WORDS, 256, number of writable words; must be ≤ 2^ADDR_W.
- BASE_ADDR, 0, memory address of the first loaded word.
- START_PC, 0, PC value presented to the control unit.
- FIFO_DEPTH, 4, buffer entries; power of two, ≥ 2.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bios_data  in  32  instruction word from the BIOS.
- bios_active  in  1  high while the BIOS is streaming; one word per cycle.
- mem_addr  out  ADDR_W  instruction-memory write address.
- mem_wdata  out  32  write data (FIFO head).
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- cu_start  out  1  one-cycle pulse that hands control to the control unit.
- cu_pc  out  ADDR_W  start PC; valid from the cu_start cycle onward.
- words_loaded  out  ADDR_W+1  count of words committed to memory.
- load_error  out  1  sticky flag: FIFO overflow or memory capacity exceeded.

Behaviour:
- Reset (async assert, sync release):
  - State = PRIME.
  - FIFO empty.
  - mem_addr = BASE_ADDR, mem_wdata = 0, mem_we = 0.
  - cu_start = 0, cu_pc = 0, words_loaded = 0, load_error = 0.
  - Reset mid-load discards buffered words; memory contents are not touched.
- Source has no backpressure. Push rule: in state LOAD, every rising edge that samples bios_active = 1 pushes bios_data.
- States:
  - PRIME: the first edge after reset release only samples inputs; no push, because the BIOS data is not yet valid. Next state is LOAD if bios_active = 1, else DRAIN.
  - LOAD: push per rule; pop per write handshake. Go to DRAIN on the first edge that samples bios_active = 0; that cycle's bios_data is not pushed.
  - DRAIN: no pushes. Go to START when the FIFO is empty and no write is pending.
  - START: cu_start = 1 for exactly one cycle; cu_pc = START_PC, held thereafter. Next state RUN.
  - RUN: terminal until reset. bios_active and bios_data are ignored; mem_we = 0.
- Write port:
  - mem_we = 1 whenever the state is LOAD or DRAIN and the FIFO is non-empty.
  - mem_wdata = FIFO head, mem_addr = current write address.
  - A write commits on an edge where mem_we and mem_ready are both high. On commit: pop the FIFO, increment mem_addr by 1, increment words_loaded.
  - mem_addr, mem_wdata and mem_we must be stable while mem_ready is low.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full; occupancy is unchanged.
  - Push while full with no pop in that cycle: the word is dropped and load_error is set.
- Capacity:
  - Once words_loaded = MEM_WORDS, further FIFO heads are popped with mem_we = 0 and discarded, and load_error is set.
  - mem_addr never exceeds BASE_ADDR + MEM_WORDS − 1 and never wraps.
- Latency: a word pushed into an empty FIFO appears on mem_we/mem_wdata in the next cycle.
- load_error does not block the handoff; cu_start is still issued.

Test Plan:
- 3-word stream 0x00000011, 0x00000022, 0x00000033 with mem_ready tied to 1 -> three writes at addresses 0, 1, 2 in order; cu_start pulses once, 2 cycles after the last write; words_loaded = 3; load_error = 0.
- 8-word stream with mem_ready = 0 for 3 cycles mid-stream, FIFO_DEPTH = 4 -> no loss, addresses 0–7 contiguous, write outputs stable during the stall.
- 8-word stream with mem_ready held low for 6 cycles -> load_error = 1; surviving words are written contiguously; cu_start still pulses once.
- MEM_WORDS = 4, 6-word stream -> only 4 writes (addresses 0–3); words_loaded = 4; load_error = 1.
- reset_n asserted low on the 2nd of 5 words -> all outputs return to reset values immediately; after release the loader re-enters PRIME and a fresh 2-word stream loads at BASE_ADDR.
- bios_active low at reset release -> no writes; cu_start pulses once; cu_pc = START_PC; re-asserting bios_active in RUN causes no writes.

Source files
------------

// File: rtl/imem_loader.sv
// Captures the BIOS instruction stream into a small FIFO and drains it into
// instruction memory, then hands control to the control unit at cu_pc.
module imem_loader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MEM_WORDS  = 256,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned START_PC   = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       bios_data,
    input  logic              bios_active,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              cu_start,
    output logic [ADDR_W-1:0] cu_pc,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_error
);

    localparam int unsigned       PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PC_C    = ADDR_W'(START_PC);
    localparam logic [ADDR_W:0]   CAP_C   = (ADDR_W + 1)'(MEM_WORDS);
    localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {PRIME, LOAD, DRAIN, START, RUN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fifo_q [FIFO_DEPTH];
    logic [31:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   loaded_q, loaded_d;
    logic              err_q, err_d;

    logic write_phase, fifo_empty, fifo_full, cap_reached;
    logic push, pop, commit;

    always_comb begin
        write_phase = (state_q == LOAD) || (state_q == DRAIN);
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == DEPTH_C);
        cap_reached = (loaded_q == CAP_C);

        mem_we    = write_phase && !fifo_empty && !cap_reached;
        mem_wdata = (write_phase && !fifo_empty) ? fifo_q[rd_ptr_q] : '0;
        mem_addr  = addr_q;
        commit    = mem_we && mem_ready;
        // Past capacity the head is discarded every cycle regardless of mem_ready.
        pop       = write_phase && !fifo_empty && (cap_reached || mem_ready);
        push      = (state_q == LOAD) && bios_active && (!fifo_full || pop);

        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = bios_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        addr_d   = addr_q;
        loaded_d = loaded_q;
        if (commit) begin
            loaded_d = loaded_q + 1'b1;
            // The final writable word leaves the address parked on the last slot.
            if (loaded_q != CAP_C - 1'b1) begin
                addr_d = addr_q + 1'b1;
            end
        end

        err_d = err_q
              | (pop && cap_reached)
              | ((state_q == LOAD) && bios_active && fifo_full && !pop);

        state_d = state_q;
        unique case (state_q)
            PRIME:   state_d = bios_active ? LOAD : DRAIN;
            LOAD:    state_d = bios_active ? LOAD : DRAIN;
            DRAIN:   state_d = fifo_empty ? START : DRAIN;
            START:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = PRIME;
        endcase

        cu_start     = (state_q == START);
        cu_pc        = ((state_q == START) || (state_q == RUN)) ? PC_C : '0;
        words_loaded = loaded_q;
        load_error   = err_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= PRIME;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_C;
            loaded_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random streams and memory stalls checked
// against a queue-based model of the loader's load/drain/handoff rules.
module tb_imem_loader;

    localparam int PH_PRIME = 0, PH_LOAD = 1, PH_DRAIN = 2, PH_START = 3, PH_RUN = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] bios_data;
    logic        bios_active, mem_ready;

    logic [7:0]  a_addr, a_pc, b_addr, b_pc;
    logic [31:0] a_wdata, b_wdata;
    logic        a_we, a_cu, a_err, b_we, b_cu, b_err;
    logic [8:0]  a_wl, b_wl;

    imem_loader #(.ADDR_W(8), .MEM_WORDS(256), .BASE_ADDR(0), .START_PC(8'h40), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .bios_data(bios_data), .bios_active(bios_active),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we), .mem_ready(mem_ready),
        .cu_start(a_cu), .cu_pc(a_pc), .words_loaded(a_wl), .load_error(a_err));

    imem_loader #(.ADDR_W(8), .MEM_WORDS(4), .BASE_ADDR(8), .START_PC(3), .FIFO_DEPTH(4)) dut_small (
        .clock(clock), .reset_n(reset_n), .bios_data(bios_data), .bios_active(bios_active),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we), .mem_ready(mem_ready),
        .cu_start(b_cu), .cu_pc(b_pc), .words_loaded(b_wl), .load_error(b_err));

    always #5 clock = ~clock;

    bit          use_small;
    logic [7:0]  o_addr, o_pc;
    logic [31:0] o_wdata;
    logic        o_we, o_cu, o_err;
    logic [8:0]  o_wl;
    assign o_addr  = use_small ? b_addr  : a_addr;
    assign o_pc    = use_small ? b_pc    : a_pc;
    assign o_wdata = use_small ? b_wdata : a_wdata;
    assign o_we    = use_small ? b_we    : a_we;
    assign o_cu    = use_small ? b_cu    : a_cu;
    assign o_err   = use_small ? b_err   : a_err;
    assign o_wl    = use_small ? b_wl    : a_wl;

    int checks = 0, errors = 0, cyc = 0, stab_viol = 0;
    bit prev_stall;
    logic        p_we;
    logic [7:0]  p_addr;
    logic [31:0] p_wdata;
    logic [31:0] wd [16];

    logic [7:0]  obs_addr[$], exp_addr[$];
    logic [31:0] obs_data[$], exp_data[$];
    int          obs_wcyc[$], obs_cu[$], exp_cu[$];

    // Reference model: a word queue, committed-word count and a loader phase.
    int          m_ph, m_loaded, m_mw, m_base, m_pc;
    bit          m_err;
    logic [31:0] m_q[$];

    function automatic void model_reset();
        m_ph = PH_PRIME; m_loaded = 0; m_err = 0; m_q.delete();
    endfunction

    function automatic void set_model(input int mw, input int base, input int pc);
        m_mw = mw; m_base = base; m_pc = pc;
    endfunction

    function automatic int model_addr();
        return m_base + ((m_loaded < m_mw) ? m_loaded : m_mw - 1);
    endfunction

    function automatic void model_edge(input logic act, input logic [31:0] dat, input logic rdy);
        int  sz;
        bit  in_wr, pop, commit, push;
        sz     = m_q.size();
        in_wr  = (m_ph == PH_LOAD) || (m_ph == PH_DRAIN);
        pop    = in_wr && sz > 0 && (m_loaded >= m_mw || rdy);
        commit = pop && m_loaded < m_mw;
        push   = (m_ph == PH_LOAD) && act;
        if (pop && !commit) m_err = 1;
        if (pop) void'(m_q.pop_front());
        if (commit) m_loaded++;
        if (push) begin
            if (sz == DEPTH && !pop) m_err = 1;
            else m_q.push_back(dat);
        end
        case (m_ph)
            PH_PRIME, PH_LOAD: m_ph = act ? PH_LOAD : PH_DRAIN;
            PH_DRAIN:          m_ph = (sz == 0) ? PH_START : PH_DRAIN;
            default:           m_ph = PH_RUN;
        endcase
    endfunction

    function automatic logic rdy_at(input int st, input int sl, input bit rnd);
        if (rnd) return ($urandom_range(3) != 0);
        return !(cyc >= st && cyc < st + sl);
    endfunction

    // One clock cycle: drive at negedge, observe, advance DUT and model together.
    task automatic step(input logic act, input logic [31:0] dat, input logic rdy);
        bios_active = act; bios_data = dat; mem_ready = rdy;
        #1;
        if (prev_stall && (o_we !== p_we || o_addr !== p_addr || o_wdata !== p_wdata)) stab_viol++;
        prev_stall = (o_we === 1'b1) && !rdy;
        p_we = o_we; p_addr = o_addr; p_wdata = o_wdata;
        if (o_we === 1'b1 && rdy) begin
            obs_addr.push_back(o_addr); obs_data.push_back(o_wdata); obs_wcyc.push_back(cyc);
        end
        if (o_cu === 1'b1) obs_cu.push_back(cyc);
        if ((m_ph == PH_LOAD || m_ph == PH_DRAIN) && m_q.size() > 0 && m_loaded < m_mw && rdy) begin
            exp_addr.push_back(8'(m_base + m_loaded)); exp_data.push_back(m_q[0]);
        end
        if (m_ph == PH_START) exp_cu.push_back(cyc);
        @(posedge clock);
        model_edge(act, dat, rdy);
        @(negedge clock);
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0; bios_active = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic stream(input int n, input bit pact, input int st, input int sl, input bit rnd, input bit tact);
        int guard;
        obs_addr.delete(); obs_data.delete(); obs_wcyc.delete(); obs_cu.delete();
        exp_addr.delete(); exp_data.delete(); exp_cu.delete();
        cyc = 0; stab_viol = 0; prev_stall = 0;
        step(pact, $urandom, rdy_at(st, sl, rnd));
        for (int i = 0; i < n; i++) step(1'b1, wd[i], rdy_at(st, sl, rnd));
        guard = 0;
        while (obs_cu.size() == 0 && guard < 80) begin
            step(1'b0, $urandom, rdy_at(st, sl, rnd));
            guard++;
        end
        for (int i = 0; i < 6; i++) step(tact, $urandom, rdy_at(st, sl, rnd));
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bios_active = 1'b0; mem_ready = 1'b0; bios_data = '0;
        repeat (2) @(negedge clock);
        checks++; if (a_we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b expected 0", a_we); end
        checks++; if (a_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %0h expected 0", a_addr); end
        checks++; if (b_addr !== 8'h08) begin errors++; $display("FAIL reset_base_addr: got %0h expected 8", b_addr); end
        checks++; if (a_wdata !== '0)   begin errors++; $display("FAIL reset_wdata: got %0h expected 0", a_wdata); end
        checks++; if (a_cu !== 1'b0 || a_pc !== 8'h00) begin errors++; $display("FAIL reset_cu: got start=%b pc=%0h expected 0/0", a_cu, a_pc); end
        checks++; if (a_wl !== '0 || a_err !== 1'b0) begin errors++; $display("FAIL reset_status: got wl=%0d err=%b expected 0/0", a_wl, a_err); end
    endtask

    task automatic test_basic();
        int last_w;
        use_small = 0; set_model(256, 0, 'h40);
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
        apply_reset();
        stream(3, 1, 0, 0, 0, 0);
        checks++; if (obs_addr.size() != 3) begin errors++; $display("FAIL basic_nwrites: got %0d expected 3", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            checks++; if (obs_addr[i] !== 8'(i)) begin errors++; $display("FAIL basic_addr%0d: got %0h expected %0h", i, obs_addr[i], i); end
            checks++; if (obs_data[i] !== wd[i]) begin errors++; $display("FAIL basic_data%0d: got %0h expected %0h", i, obs_data[i], wd[i]); end
        end
        last_w = (obs_wcyc.size() > 0) ? obs_wcyc[$] : -100;
        checks++; if (obs_cu.size() != 1) begin errors++; $display("FAIL basic_cu_count: got %0d expected 1", obs_cu.size()); end
        else begin
            checks++; if (obs_cu[0] - last_w != 2) begin errors++; $display("FAIL basic_cu_delay: got %0d expected 2", obs_cu[0] - last_w); end
        end
        checks++; if (o_wl !== 9'd3)  begin errors++; $display("FAIL basic_wl: got %0d expected 3", o_wl); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", o_err); end
        checks++; if (o_pc !== 8'h40) begin errors++; $display("FAIL basic_pc: got %0h expected 40", o_pc); end
    endtask

    task automatic test_stall();
        use_small = 0; set_model(256, 0, 'h40);
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        apply_reset();
        stream(8, 1, 4, 3, 0, 0);
        checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL stall_nwrites: got %0d expected 8", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
            checks++; if (obs_addr[i] !== 8'(i) || obs_data[i] !== wd[i]) begin
                errors++; $display("FAIL stall_write%0d: got %0h@%0h expected %0h@%0h", i, obs_data[i], obs_addr[i], wd[i], i);
            end
        end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stab_viol); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL stall_err: got %b expected 0", o_err); end
        checks++; if (obs_cu.size() != 1) begin errors++; $display("FAIL stall_cu_count: got %0d expected 1", obs_cu.size()); end
    endtask

    task automatic test_overflow();
        use_small = 0; set_model(256, 0, 'h40);
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        apply_reset();
        stream(8, 1, 3, 6, 0, 0);
        checks++; if (obs_addr.size() != exp_addr.size()) begin errors++; $display("FAIL ovf_nwrites: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL ovf_write%0d: got %0h@%0h expected %0h@%0h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", o_err); end
        checks++; if (o_wl !== 9'(m_loaded)) begin errors++; $display("FAIL ovf_wl: got %0d expected %0d", o_wl, m_loaded); end
        checks++; if (obs_cu.size() != 1 || exp_cu.size() != 1 || obs_cu[0] != exp_cu[0]) begin
            errors++; $display("FAIL ovf_cu: got %0d pulses expected 1 at cycle %0d", obs_cu.size(), exp_cu.size() ? exp_cu[0] : -1);
        end
    endtask

    task automatic test_capacity();
        use_small = 1; set_model(4, 8, 3);
        for (int i = 0; i < 6; i++) wd[i] = $urandom;
        apply_reset();
        stream(6, 1, 0, 0, 0, 0);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL cap_nwrites: got %0d expected 4", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks++; if (obs_addr[i] !== 8'(8 + i) || obs_data[i] !== wd[i]) begin
                errors++; $display("FAIL cap_write%0d: got %0h@%0h expected %0h@%0h", i, obs_data[i], obs_addr[i], wd[i], 8 + i);
            end
        end
        checks++; if (o_wl !== 9'd4)   begin errors++; $display("FAIL cap_wl: got %0d expected 4", o_wl); end
        checks++; if (o_err !== 1'b1)  begin errors++; $display("FAIL cap_err: got %b expected 1", o_err); end
        checks++; if (o_addr !== 8'd11) begin errors++; $display("FAIL cap_addr_limit: got %0h expected b", o_addr); end
        checks++; if (obs_cu.size() != 1 || o_pc !== 8'd3) begin errors++; $display("FAIL cap_cu: got %0d pulses pc=%0h expected 1 pc=3", obs_cu.size(), o_pc); end
        use_small = 0;
    endtask

    task automatic test_midreset();
        use_small = 0; set_model(256, 0, 'h40);
        apply_reset();
        cyc = 0; prev_stall = 0;
        step(1'b1, $urandom, 1'b1);
        step(1'b1, 32'hA1, 1'b1);
        bios_active = 1'b1; bios_data = 32'hA2; mem_ready = 1'b1;
        #2;
        checks++; if (a_we !== 1'b1 || a_wdata !== 32'hA1) begin errors++; $display("FAIL mrst_pre: got we=%b data=%0h expected 1/a1", a_we, a_wdata); end
        reset_n = 1'b0;
        #1;
        checks++; if (a_we !== 1'b0 || a_wdata !== '0 || a_addr !== 8'h00) begin
            errors++; $display("FAIL mrst_async: got we=%b data=%0h addr=%0h expected 0/0/0", a_we, a_wdata, a_addr);
        end
        checks++; if (a_cu !== 1'b0 || a_pc !== '0 || a_wl !== '0 || a_err !== 1'b0) begin
            errors++; $display("FAIL mrst_status: got cu=%b pc=%0h wl=%0d err=%b expected zeros", a_cu, a_pc, a_wl, a_err);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        wd[0] = $urandom; wd[1] = $urandom;
        stream(2, 1, 0, 0, 0, 0);
        checks++; if (obs_addr.size() != 2) begin errors++; $display("FAIL mrst_nwrites: got %0d expected 2", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            checks++; if (obs_addr[i] !== 8'(i) || obs_data[i] !== wd[i]) begin
                errors++; $display("FAIL mrst_write%0d: got %0h@%0h expected %0h@%0h", i, obs_data[i], obs_addr[i], wd[i], i);
            end
        end
        checks++; if (o_wl !== 9'd2 || obs_cu.size() != 1) begin errors++; $display("FAIL mrst_done: got wl=%0d pulses=%0d expected 2/1", o_wl, obs_cu.size()); end
    endtask

    task automatic test_idle();
        use_small = 0; set_model(256, 0, 'h40);
        apply_reset();
        stream(0, 0, 0, 0, 0, 1);
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL idle_writes: got %0d expected 0", obs_addr.size()); end
        checks++; if (obs_cu.size() != 1) begin errors++; $display("FAIL idle_cu_count: got %0d expected 1", obs_cu.size()); end
        else begin
            checks++; if (obs_cu[0] != 2) begin errors++; $display("FAIL idle_cu_cycle: got %0d expected 2", obs_cu[0]); end
        end
        checks++; if (o_pc !== 8'h40) begin errors++; $display("FAIL idle_pc: got %0h expected 40", o_pc); end
        checks++; if (o_wl !== '0 || o_err !== 1'b0) begin errors++; $display("FAIL idle_status: got wl=%0d err=%b expected 0/0", o_wl, o_err); end
    endtask

    task automatic test_random();
        int n;
        use_small = 0; set_model(256, 0, 'h40);
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) wd[i] = $urandom;
            apply_reset();
            stream(n, 1, 0, 0, 1, 0);
            checks++; if (obs_addr.size() != exp_addr.size()) begin errors++; $display("FAIL rnd%0d_nwrites: got %0d expected %0d", it, obs_addr.size(), exp_addr.size()); end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    errors++; $display("FAIL rnd%0d_write%0d: got %0h@%0h expected %0h@%0h", it, i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
                end
            end
            checks++; if (o_wl !== 9'(m_loaded) || o_err !== m_err || o_addr !== 8'(model_addr())) begin
                errors++; $display("FAIL rnd%0d_status: got wl=%0d err=%b addr=%0h expected %0d/%b/%0h", it, o_wl, o_err, o_addr, m_loaded, m_err, model_addr());
            end
            checks++; if (obs_cu.size() != 1 || exp_cu.size() != 1 || obs_cu[0] != exp_cu[0]) begin
                errors++; $display("FAIL rnd%0d_cu: got %0d pulses expected 1 at cycle %0d", it, obs_cu.size(), exp_cu.size() ? exp_cu[0] : -1);
            end
            checks++; if (stab_viol != 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d changes expected 0", it, stab_viol); end
        end
    endtask

    initial begin
        use_small = 0;
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_capacity();
        test_midreset();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
